// File: rtl/vedic_mul_accumulator.sv
// vedic_mul_accumulator: pipelined unsigned 32x32 multiply-accumulate for
// dot-product packets.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : operand handshake for a, b, in_last
//   acc_clr         : synchronous abort; empties the pipeline and clears state
//   out_valid/ready : result handshake for acc_out, term_cnt, ovf
// Pipeline: accept -> stage 1 (operands) -> stage 2 (product) -> accumulate.

// Recursive Vedic (Urdhva Tiryagbhyam) multiplier; W must be a power of two >= 2.
module vedic_mul_n #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  if (W == 2) begin : g_base
    // 2x2 multiply built from two half adders.
    logic c1;
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
  end else begin : g_rec
    localparam int unsigned H  = W / 2;
    localparam int unsigned PW = 2 * W;
    logic [W-1:0]  ll, lh, hl, hh;
    logic [PW-1:0] mid;
    vedic_mul_n #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_mul_n #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
    vedic_mul_n #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_mul_n #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
    // Cross products land H bits up; outer products concatenate directly.
    assign mid = PW'(lh) + PW'(hl);
    assign p   = {hh, ll} + (mid << H);
  end
endmodule

// Unsigned 32x32 -> 64 Vedic multiplier.
module vedic_32bit_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  vedic_mul_n #(.W(32)) u_mul (.a(a), .b(b), .p(p));
endmodule

module vedic_mul_accumulator #(
  parameter int unsigned ACC_WIDTH = 72,
  parameter int unsigned CNT_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  input  logic                 in_last,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic [CNT_WIDTH-1:0] term_cnt,
  output logic                 ovf
);
  localparam int unsigned OPW = 32;
  localparam int unsigned PRW = 64;
  localparam int unsigned SW  = ACC_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

  state_e               state_q, state_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [OPW-1:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                 s1_last_q, s1_last_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [PRW-1:0]       s2_prod_q, s2_prod_d;
  logic                 s2_last_q, s2_last_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_out_q, acc_out_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, term_cnt_q, term_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic [PRW-1:0]       prod;
  logic [SW-1:0]        acc_sum;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 accept;

  vedic_32bit_mul u_mul (.a(s1_a_q), .b(s1_b_q), .p(prod));

  assign acc_sum = SW'(acc_q) + SW'(s2_prod_q);
  assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Ready only while collecting a packet; acc_clr and rst block acceptance.
  assign in_ready = ((state_q == IDLE) || (state_q == ACCUM)) && !acc_clr && !rst;
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign term_cnt  = term_cnt_q;
  assign ovf       = ovf_q;

  // Next-state, pipeline and accumulator logic.
  always_comb begin
    state_d     = state_q;
    s1_valid_d  = accept;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s1_valid_q;
    s2_prod_d   = prod;
    s2_last_d   = s1_last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    acc_out_d   = acc_out_q;
    term_cnt_d  = term_cnt_q;

    if (accept) begin
      s1_a_d    = a;
      s1_b_d    = b;
      s1_last_d = in_last;
    end

    if (s2_valid_q) begin
      acc_d = acc_sum[ACC_WIDTH-1:0];
      cnt_d = cnt_inc;
      ovf_d = ovf_q | acc_sum[ACC_WIDTH];
    end

    case (state_q)
      IDLE:  if (accept) state_d = in_last ? DRAIN : ACCUM;
      ACCUM: if (accept && in_last) state_d = DRAIN;
      DRAIN: begin
        if (s2_valid_q && s2_last_q) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          acc_out_d   = acc_sum[ACC_WIDTH-1:0];
          term_cnt_d  = cnt_inc;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          acc_out_d   = '0;
          term_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over acceptance, accumulation and the output handshake.
    if (acc_clr) begin
      state_d     = IDLE;
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      acc_out_d   = '0;
      term_cnt_d  = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      term_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      acc_out_q   <= acc_out_d;
      term_cnt_q  <= term_cnt_d;
    end
  end

endmodule

// File: tb/tb_vedic_mul_accumulator.sv
// Directed bench for vedic_mul_accumulator (ACC_WIDTH=72, CNT_WIDTH=9).
module tb_vedic_mul_accumulator;
  localparam int unsigned AW = 72;
  localparam int unsigned CW = 9;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   a;
  logic [31:0]   b;
  logic          in_last;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] acc_out;
  logic [CW-1:0] term_cnt;
  logic          ovf;

  int nchk = 0;
  int nerr = 0;

  vedic_mul_accumulator #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_last(in_last), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .term_cnt(term_cnt), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair for exactly one edge.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic last);
    in_valid = 1'b1; a = av; b = bv; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_big;
    logic         stalled;
    logic         seen_valid;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_last = 1'b0;
    acc_clr = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    step();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_acc_out", 128'(acc_out), 128'(0));
    chk("rst_term_cnt", 128'(term_cnt), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Single max-value term, accepted on the first edge after reset release.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("t1_drain_in_ready", 128'(in_ready), 128'(0));
    step();
    chk("t1_e1_out_valid", 128'(out_valid), 128'(0));
    step();
    chk("t1_out_valid", 128'(out_valid), 128'(1));
    chk("t1_acc_out", 128'(acc_out), 128'h00FF_FFFF_FE00_0000_01);
    chk("t1_term_cnt", 128'(term_cnt), 128'(1));
    chk("t1_ovf", 128'(ovf), 128'(0));
    chk("t1_hold_in_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    step();
    chk("t1_hs_out_valid", 128'(out_valid), 128'(0));
    chk("t1_hs_acc_out", 128'(acc_out), 128'(0));
    chk("t1_hs_in_ready", 128'(in_ready), 128'(1));

    // Back-to-back 3*4 + 5*6 + 7*8 = 0x62, out_ready held high.
    stalled = 1'b0;
    in_valid = 1'b1; a = 3; b = 4; in_last = 1'b0;
    if (!in_ready) stalled = 1'b1;
    step();
    a = 5; b = 6;
    if (!in_ready) stalled = 1'b1;
    step();
    a = 7; b = 8; in_last = 1'b1;
    if (!in_ready) stalled = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t2_no_stall", 128'(stalled), 128'(0));
    step();
    chk("t2_e1_out_valid", 128'(out_valid), 128'(0));
    step();
    chk("t2_out_valid", 128'(out_valid), 128'(1));
    chk("t2_acc_out", 128'(acc_out), 128'h62);
    chk("t2_term_cnt", 128'(term_cnt), 128'(3));
    chk("t2_hs_cycle_in_ready", 128'(in_ready), 128'(0));
    step();
    chk("t2_after_hs_out_valid", 128'(out_valid), 128'(0));
    chk("t2_after_hs_in_ready", 128'(in_ready), 128'(1));

    // Result held with out_ready low; offered input must be ignored.
    out_ready = 1'b0;
    send(32'h1234, 32'h10, 1'b1);
    step();
    step();
    chk("t3_out_valid", 128'(out_valid), 128'(1));
    in_valid = 1'b1; a = 7; b = 7; in_last = 1'b1;
    stalled = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || acc_out !== AW'(32'h12340) || out_valid !== 1'b1)
        stalled = 1'b1;
      step();
    end
    chk("t3_hold_stable", 128'(stalled), 128'(0));
    chk("t3_hold_acc_out", 128'(acc_out), 128'h12340);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_hs_acc_out", 128'(acc_out), 128'(0));
    chk("t3_hs_out_valid", 128'(out_valid), 128'(0));
    send(32'd2, 32'd3, 1'b1);
    step();
    step();
    chk("t3_next_acc_out", 128'(acc_out), 128'(6));
    chk("t3_next_term_cnt", 128'(term_cnt), 128'(1));
    step();

    // 257 max-value terms: wraps past 2^72, sets ovf.
    stalled = 1'b0;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_last = (i == 256);
      if (!in_ready) stalled = 1'b1;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_no_stall", 128'(stalled), 128'(0));
    step();
    step();
    exp_big = (128'(257) * 128'hFFFF_FFFE_0000_0001) & ((128'(1) << AW) - 128'(1));
    chk("t4_out_valid", 128'(out_valid), 128'(1));
    chk("t4_acc_out", 128'(acc_out), exp_big);
    chk("t4_acc_out_const", 128'(acc_out), 128'h00FF_FFFD_FE00_0001_01);
    chk("t4_term_cnt", 128'(term_cnt), 128'(257));
    chk("t4_ovf", 128'(ovf), 128'(1));
    step();
    chk("t4_hs_ovf", 128'(ovf), 128'(0));
    chk("t4_hs_term_cnt", 128'(term_cnt), 128'(0));

    // acc_clr with two terms in flight aborts the packet.
    in_valid = 1'b1; a = 5; b = 5; in_last = 1'b0;
    step();
    a = 6; b = 6; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    acc_clr = 1'b1;
    #1;
    chk("t5_clr_in_ready", 128'(in_ready), 128'(0));
    step();
    acc_clr = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) seen_valid = 1'b1;
      step();
    end
    chk("t5_no_out_valid", 128'(seen_valid), 128'(0));
    chk("t5_idle_in_ready", 128'(in_ready), 128'(1));
    send(32'd9, 32'd9, 1'b1);
    step();
    step();
    chk("t5_acc_out", 128'(acc_out), 128'd81);
    chk("t5_term_cnt", 128'(term_cnt), 128'(1));
    step();

    // rst pulsed while draining discards the packet.
    send(32'h10, 32'h10, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_in_ready", 128'(in_ready), 128'(0));
    chk("t6_rst_out_valid", 128'(out_valid), 128'(0));
    step();
    step();
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) seen_valid = 1'b1;
      step();
    end
    chk("t6_no_out_valid", 128'(seen_valid), 128'(0));
    send(32'd1, 32'd1, 1'b1);
    step();
    step();
    chk("t6_acc_out", 128'(acc_out), 128'(1));

    // rst in HOLD clears held outputs without waiting for a clock edge.
    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("t7_async_out_valid", 128'(out_valid), 128'(0));
    chk("t7_async_acc_out", 128'(acc_out), 128'(0));
    chk("t7_async_term_cnt", 128'(term_cnt), 128'(0));
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
